// File: rtl/csrs_user_pkg.sv
// Shared constants and address decode for the user-level counter/timer CSRs.
package csrs_user_pkg;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_HPM_BASE  = 12'hC03;
  localparam logic [11:0] CSR_HI_OFFSET = 12'h080;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             hi;
  } csr_dec_t;

  // Both halves fold onto the 0xC00..0xC1F window once the hi-offset bit is cleared.
  function automatic csr_dec_t csr_decode(input logic [11:0] addr, input int unsigned n_ctr);
    csr_dec_t    d;
    logic [11:0] base;
    base  = addr & ~CSR_HI_OFFSET;
    d.hi  = addr[7];
    d.idx = base[IDX_W-1:0];
    d.hit = (base[11:5] == CSR_CYCLE[11:5]) && (32'(d.idx) < n_ctr);
    return d;
  endfunction
endpackage

// File: rtl/csrs_user_counter64.sv
// 64-bit counter with a variable increment and 32-bit half presets.
module csrs_user_counter64 #(
  parameter int AMT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_en_i,
  input  logic [AMT_W-1:0] inc_amt_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [63:0]      value_o
);
  logic [63:0] cnt_q, cnt_d;

  // A preset replaces the increment for that cycle; the other half is untouched (no carry).
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)       cnt_d = {cnt_q[63:32], wdata_i};
    else if (wr_hi_i)  cnt_d = {wdata_i, cnt_q[31:0]};
    else if (inc_en_i) cnt_d = cnt_q + 64'(inc_amt_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
endmodule

// File: rtl/csrs_user_counters.sv
// User counter/timer CSR bank: cycle, time, instret, hpmcounters with a registered read port.
module csrs_user_counters
  import csrs_user_pkg::*;
#(
  parameter int HPM_NUM  = 4,
  parameter int RETIRE_W = 2,
  parameter int TIME_DIV = 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  RDEN,
  input  logic [11:0]                           RADDR,
  output logic                                  RVALID,
  output logic [31:0]                           RDATA,
  input  logic                                  WREN,
  input  logic [11:0]                           WADDR,
  input  logic [31:0]                           WDATA,
  input  logic [RETIRE_W-1:0]                   RETIRE,
  input  logic [(HPM_NUM > 0 ? HPM_NUM : 1)-1:0] HPM_EVENT,
  input  logic [3+HPM_NUM-1:0]                  INHIBIT
);
  localparam int NCTR  = 3 + HPM_NUM;
  localparam int PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;
  csr_dec_t         wdec, rdec;

  logic [NCTR-1:0]                inc_en, wr_lo, wr_hi;
  logic [NCTR-1:0][RETIRE_W-1:0]  inc_amt;
  logic [NCTR-1:0][63:0]          cnt;

  // Prescaler free-runs regardless of INHIBIT[1]; the inhibit only gates the time counter.
  assign tick  = (pre_q == PRE_W'(TIME_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);
  assign wdec  = csr_decode(WADDR, NCTR);
  assign rdec  = csr_decode(RADDR, NCTR);

  for (genvar i = 0; i < NCTR; i++) begin : g_ctr
    if (i == 0) begin : g_cycle
      assign inc_en[i]  = ~INHIBIT[i];
      assign inc_amt[i] = RETIRE_W'(1);
    end else if (i == 1) begin : g_time
      assign inc_en[i]  = ~INHIBIT[i] & tick;
      assign inc_amt[i] = RETIRE_W'(1);
    end else if (i == 2) begin : g_instret
      assign inc_en[i]  = ~INHIBIT[i];
      assign inc_amt[i] = RETIRE;
    end else begin : g_hpm
      assign inc_en[i]  = ~INHIBIT[i] & HPM_EVENT[i-3];
      assign inc_amt[i] = RETIRE_W'(1);
    end

    assign wr_lo[i] = WREN & wdec.hit & ~wdec.hi & (wdec.idx == IDX_W'(i));
    assign wr_hi[i] = WREN & wdec.hit &  wdec.hi & (wdec.idx == IDX_W'(i));

    csrs_user_counter64 #(.AMT_W(RETIRE_W)) u_cnt (
      .clk_i    (CLK),
      .rst_i    (RST),
      .inc_en_i (inc_en[i]),
      .inc_amt_i(inc_amt[i]),
      .wr_lo_i  (wr_lo[i]),
      .wr_hi_i  (wr_hi[i]),
      .wdata_i  (WDATA),
      .value_o  (cnt[i])
    );
  end

  // Read mux samples the pre-update counter values; misses read as zero.
  always_comb begin
    rdata_d = '0;
    if (RDEN && rdec.hit) begin
      for (int k = 0; k < NCTR; k++) begin
        if (rdec.idx == IDX_W'(k)) rdata_d = rdec.hi ? cnt[k][63:32] : cnt[k][31:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pre_q    <= pre_d;
      rvalid_q <= RDEN;
      rdata_q  <= rdata_d;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
endmodule

// File: tb/tb_csrs_user_counters.sv
// Directed plus randomized bench for csrs_user_counters against a 64-bit behavioural model.
module tb_csrs_user_counters;
  localparam int HPM_NUM  = 4;
  localparam int RETIRE_W = 2;
  localparam int TIME_DIV = 4;
  localparam int NCTR     = 3 + HPM_NUM;

  logic                CLK = 1'b0;
  logic                RST;
  logic                RDEN;
  logic [11:0]         RADDR;
  logic                RVALID;
  logic [31:0]         RDATA;
  logic                WREN;
  logic [11:0]         WADDR;
  logic [31:0]         WDATA;
  logic [RETIRE_W-1:0] RETIRE;
  logic [HPM_NUM-1:0]  HPM_EVENT;
  logic [NCTR-1:0]     INHIBIT;

  always #5 CLK = ~CLK;

  csrs_user_counters #(.HPM_NUM(HPM_NUM), .RETIRE_W(RETIRE_W), .TIME_DIV(TIME_DIV)) dut (
    .CLK(CLK), .RST(RST), .RDEN(RDEN), .RADDR(RADDR), .RVALID(RVALID), .RDATA(RDATA),
    .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA), .RETIRE(RETIRE), .HPM_EVENT(HPM_EVENT),
    .INHIBIT(INHIBIT)
  );

  // Reference state: plain 64-bit integers and an integer prescaler.
  logic [63:0] m_cnt [NCTR];
  int          m_pre;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int off = int'(a);
    if (off >= 'hC00 && off < 'hC00 + NCTR) return m_cnt[off - 'hC00][31:0];
    if (off >= 'hC80 && off < 'hC80 + NCTR) return m_cnt[off - 'hC80][63:32];
    return 32'h0;
  endfunction

  task automatic model_edge();
    int  off;
    bit  tick;
    logic [63:0] inc;
    if (RST) begin
      for (int i = 0; i < NCTR; i++) m_cnt[i] = 64'h0;
      m_pre = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
      return;
    end
    m_rvalid = RDEN;
    m_rdata  = RDEN ? m_read(RADDR) : 32'h0;
    tick  = (m_pre == TIME_DIV - 1);
    m_pre = (m_pre + 1) % TIME_DIV;
    off   = int'(WADDR);
    for (int i = 0; i < NCTR; i++) begin
      if (WREN && off == 'hC00 + i)      m_cnt[i][31:0]  = WDATA;
      else if (WREN && off == 'hC80 + i) m_cnt[i][63:32] = WDATA;
      else if (!INHIBIT[i]) begin
        case (i)
          0:       inc = 64'd1;
          1:       inc = tick ? 64'd1 : 64'd0;
          2:       inc = 64'(RETIRE);
          default: inc = HPM_EVENT[i-3] ? 64'd1 : 64'd0;
        endcase
        m_cnt[i] = m_cnt[i] + inc;
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    chk("rvalid", {31'h0, RVALID}, {31'h0, m_rvalid});
    chk("rdata", RDATA, m_rdata);
  endtask

  task automatic idle();
    RDEN = 1'b0; WREN = 1'b0; RETIRE = '0; HPM_EVENT = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1; idle(); cyc(); RST = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    RDEN = 1'b1; RADDR = a;
  endtask

  function automatic logic [11:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 4) return 12'(12'hC00 + $urandom_range(0, NCTR));
    if (r < 8) return 12'(12'hC80 + $urandom_range(0, NCTR));
    return 12'($urandom);
  endfunction

  initial begin
    RADDR = '0; WADDR = '0; WDATA = '0; INHIBIT = '0;
    RST = 1'b1; idle();
    cyc(); cyc();
    chk("reset_rvalid", {31'h0, RVALID}, 32'h0);
    chk("reset_rdata", RDATA, 32'h0);
    RST = 1'b0;

    // Cycle counter read every cycle: pre-increment values 0,1,2,...
    for (int i = 0; i < 10; i++) begin
      rd(12'hC00); cyc();
      chk("cycle_seq", RDATA, 32'(i));
    end

    // Low-half preset then carry into the high half.
    idle(); WREN = 1'b1; WADDR = 12'hC00; WDATA = 32'hFFFF_FFFF; cyc();
    idle(); rd(12'hC00); cyc();
    chk("cycle_lo_wr", RDATA, 32'hFFFF_FFFF);
    rd(12'hC80); cyc();
    chk("cycle_carry", RDATA, 32'h1);

    // Time prescaler: 20 clocks at TIME_DIV=4, then with time inhibited.
    do_reset();
    repeat (20) cyc();
    rd(12'hC01); cyc();
    chk("time_div", RDATA, 32'd5);
    INHIBIT = NCTR'(2);
    do_reset();
    repeat (20) cyc();
    rd(12'hC01); cyc();
    chk("time_inhib", RDATA, 32'd0);
    INHIBIT = '0;

    // instret with RETIRE=2, then a hi-half preset during a retiring cycle.
    do_reset();
    RETIRE = 2'd2; repeat (8) cyc();
    idle(); rd(12'hC02); cyc();
    chk("instret", RDATA, 32'd16);
    idle(); RETIRE = 2'd2; WREN = 1'b1; WADDR = 12'hC82; WDATA = 32'hA; cyc();
    idle(); rd(12'hC82); cyc();
    chk("instret_hi", RDATA, 32'hA);
    rd(12'hC02); cyc();
    chk("instret_lo_hold", RDATA, 32'd16);

    // hpm events and unmapped reads.
    idle();
    repeat (3) begin
      HPM_EVENT = 4'b0001; cyc();
      HPM_EVENT = 4'b0000; cyc();
    end
    rd(12'hC03); cyc();
    chk("hpm0", RDATA, 32'd3);
    rd(12'(12'hC03 + HPM_NUM)); cyc();
    chk("unimpl_hpm", RDATA, 32'd0);
    chk("unimpl_hpm_vld", {31'h0, RVALID}, 32'h1);
    rd(12'h123); cyc();
    chk("unmapped", RDATA, 32'd0);
    chk("unmapped_vld", {31'h0, RVALID}, 32'h1);

    // Same-cycle read and write of one half.
    idle(); rd(12'hC00); WREN = 1'b1; WADDR = 12'hC00; WDATA = 32'h55; cyc();
    WREN = 1'b0; cyc();
    chk("rw_new", RDATA, 32'h55);

    // Randomized traffic, including mid-read resets.
    for (int n = 0; n < 600; n++) begin
      RST       = ($urandom_range(0, 60) == 0);
      RDEN      = $urandom_range(0, 3) != 0;
      RADDR     = rand_addr();
      WREN      = $urandom_range(0, 5) == 0;
      WADDR     = rand_addr();
      WDATA     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      RETIRE    = RETIRE_W'($urandom);
      HPM_EVENT = HPM_NUM'($urandom);
      INHIBIT   = NCTR'($urandom) & NCTR'($urandom);
      cyc();
    end
    RST = 1'b0; idle(); INHIBIT = '0;
    for (int i = 0; i < NCTR; i++) begin
      rd(12'(12'hC00 + i)); cyc();
      rd(12'(12'hC80 + i)); cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csrs_user_counters.md
# csrs_user_counters

User-level CSR file providing the RISC-V unprivileged counter/timer CSRs: `cycle`, `time`, `instret`, and `HPM_NUM` `hpmcounterN` registers, each 64 bits wide and exposed as lo/hi 32-bit halves. It sits beside the machine-level CSR bank behind the core's CSR access unit. Reads use a one-cycle registered read port; writes preset counter halves. Privilege checks and `mcounteren` gating are done upstream, so every access reaching this block is legal.

## Interface
- `HPM_NUM`, 4, number of implemented hpmcounters (3 .. 3+HPM_NUM-1), range 0..29
- `RETIRE_W`, 2, width of per-cycle retire count
- `TIME_DIV`, 1, `time` increments once every TIME_DIV clocks (≥1)

- `CLK` in 1 clock
- `RST` in 1 synchronous, active-high reset
- `RDEN` in 1 read request
- `RADDR` in 12 CSR read address
- `RVALID` out 1 read data valid
- `RDATA` out 32 read data
- `WREN` in 1 write request
- `WADDR` in 12 CSR write address
- `WDATA` in 32 write data
- `RETIRE` in RETIRE_W instructions retired this cycle
- `HPM_EVENT` in HPM_NUM per-counter event strobe (+1 when high)
- `INHIBIT` in 3+HPM_NUM per-counter increment inhibit; bit0 cycle, bit1 time, bit2 instret, bit(3+k) hpm k

## Operation
- Address map: lo half 0xC00+i, hi half 0xC80+i; i=0 cycle, 1 time, 2 instret, 3..3+HPM_NUM-1 hpm.
- Increment per clock unless inhibited: cycle +1; instret +RETIRE (zero-extended); hpm k +1 when HPM_EVENT[k]; time +1 when prescaler reaches TIME_DIV-1.
- Time prescaler counts 0..TIME_DIV-1, wraps to 0, free-running irrespective of INHIBIT[1]; INHIBIT[1] only suppresses the `time` increment.
- All counters wrap modulo 2^64; carry from lo into hi in the same cycle.
- Write: WREN with mapped WADDR loads WDATA into that half. In that cycle the written counter does not increment; the other half holds its old value (no carry propagation).
- Unmapped writes (including unimplemented hpm indices) ignored.
- Unmapped reads (including unimplemented hpm indices, 0xC03+HPM_NUM..0xC1F) return 0 with RVALID.
- RDEN and WREN are independent and may both be asserted in one cycle.

## Timing
- Reset: all counters, prescaler, RVALID, RDATA = 0.
- Read latency 1: RVALID = RDEN of previous cycle; RDATA = value of addressed half as held at the sampling edge (pre-increment, pre-write). RDATA = 0 when the previous cycle had no RDEN.
- Back-to-back reads every cycle supported; no stall, no busy.
- Read and write to same half in the same cycle: RDATA returns the old value; the new value is visible from the next read.
- Reading lo then hi is not atomic; software retries hi/lo/hi. No latching.
- RST asserted mid-read: RVALID = 0 next cycle; in-flight read dropped.

## Structure
- Package `csrs_user_pkg`: CSR_CYCLE/TIME/INSTRET base constants, CSR_HPM_BASE, CSR_HI_OFFSET (0x80), and a helper decoding addr → {hit, index, hi}.
- Sub-module `csrs_user_counter64`: 64-bit counter with increment amount, enable, lo/hi write strobes and 32-bit write data. Instantiated 3+HPM_NUM times via generate.
- Top: address decode, prescaler, registered read mux.

## Test plan
- Reset then read 0xC00 each cycle for 10 cycles → RVALID one cycle after each RDEN; values 0,1,2,… per read (pre-increment sampling).
- Write 0xC00=0xFFFF_FFFF; next cycle read 0xC00 → 0xFFFF_FFFF; after one more cycle read 0xC80 → 1 (carry).
- TIME_DIV=4, 20 cycles after reset read 0xC01 → 5; with INHIBIT[1]=1 throughout → 0.
- RETIRE=2 for 8 cycles, then 0 → 0xC02 reads 16; write 0xC82=0xA during a RETIRE=2 cycle → hi=0xA, lo unchanged that cycle.
- HPM_EVENT[0] pulsed 3 times → 0xC03 reads 3; read 0xC03+HPM_NUM and 0x123 → 0 with RVALID=1.
- Same-cycle read+write to 0xC00 with WDATA=0x55 → RDATA old value; the following read returns 0x55.
